hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline control for the 5-stage core.
// Turns stage status (fetch/data hits, load-use in EX, MEM redirect/halt)
// into the freeze/flush controls of every pipeline latch and the PC enable,
// and tracks data-memory wait and halt drain in a small registered FSM.
// Optional feature macro: HAZARD_PERF_EN adds stall/flush event counters.
module hazard_ctrl #(
    parameter int CNT_W      = 32,
    parameter int HALT_DRAIN = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_dREN,
    input  logic [4:0] ex_rd,
    input  logic       mem_dREN,
    input  logic       mem_dWEN,
    input  logic       br_taken,
    input  logic       halt_mem,
    output logic       pc_en,
    output logic       fd_freeze,
    output logic       fd_flush,
    output logic       dex_freeze,
    output logic       dex_flush,
    output logic       xm_freeze,
    output logic       xm_flush,
    output logic       mw_freeze,
    output logic       halted
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Drain counter load value: HALT_DRAIN-1 leaves exactly HALT_DRAIN DRAIN cycles.
    localparam logic [3:0] DRAIN_INIT = 4'(HALT_DRAIN - 1);

    state_t     state_r;
    logic [3:0] drain_cnt_r;

    logic memwait_s;
    logic loaduse_s;
    logic run_like_s;

    // Hazard detection terms shared by the FSM and the output decode.
    always_comb begin
        memwait_s  = (mem_dREN | mem_dWEN) & ~dhit;
        loaduse_s  = ex_dREN & (ex_rd != 5'd0) & ((ex_rd == id_rs) | (ex_rd == id_rt));
        run_like_s = (state_r == ST_RUN) | (state_r == ST_DWAIT);
    end

    // Control FSM: memory wait tracking, halt capture and drain countdown.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= ST_RUN;
            drain_cnt_r <= 4'd0;
        end else begin
            case (state_r)
                ST_RUN, ST_DWAIT: begin
                    if (memwait_s) begin
                        state_r <= ST_DWAIT;
                    end else if (halt_mem) begin
                        state_r     <= ST_DRAIN;
                        drain_cnt_r <= DRAIN_INIT;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_r == 4'd0) begin
                        state_r <= ST_HALT;
                    end else begin
                        drain_cnt_r <= drain_cnt_r - 4'd1;
                    end
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    state_r     <= ST_RUN;
                    drain_cnt_r <= 4'd0;
                end
            endcase
        end
    end

    // Latch control decode; memwait outranks halt, halt outranks branch redirect.
    always_comb begin
        pc_en      = 1'b0;
        fd_freeze  = 1'b0;
        fd_flush   = 1'b0;
        dex_freeze = 1'b0;
        dex_flush  = 1'b0;
        xm_freeze  = 1'b0;
        xm_flush   = 1'b0;
        mw_freeze  = 1'b0;
        halted     = 1'b0;
        if (RST) begin
            fd_flush  = 1'b1;
            dex_flush = 1'b1;
            xm_flush  = 1'b1;
        end else begin
            case (state_r)
                ST_RUN, ST_DWAIT: begin
                    if (memwait_s) begin
                        fd_freeze  = 1'b1;
                        dex_freeze = 1'b1;
                        xm_freeze  = 1'b1;
                        mw_freeze  = 1'b1;
                    end else if (halt_mem || br_taken) begin
                        pc_en     = br_taken & ~halt_mem;
                        fd_flush  = 1'b1;
                        dex_flush = 1'b1;
                        xm_flush  = 1'b1;
                    end else if (loaduse_s) begin
                        fd_freeze = 1'b1;
                        dex_flush = 1'b1;
                    end else if (!ihit) begin
                        fd_flush = 1'b1;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    fd_flush  = 1'b1;
                    dex_flush = 1'b1;
                    xm_flush  = 1'b1;
                end
                ST_HALT: begin
                    halted     = 1'b1;
                    fd_freeze  = 1'b1;
                    dex_freeze = 1'b1;
                    xm_freeze  = 1'b1;
                    mw_freeze  = 1'b1;
                end
                default: begin
                    fd_flush  = 1'b1;
                    dex_flush = 1'b1;
                    xm_flush  = 1'b1;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic stall_ev_s;
    logic flush_ev_s;

    // Performance events: front-end stall cycles and taken redirects.
    always_comb begin
        stall_ev_s = ~RST & run_like_s & ~pc_en;
        flush_ev_s = ~RST & run_like_s & ~memwait_s & ~halt_mem & br_taken;
    end

    // Saturating event counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt <= {CNT_W{1'b0}};
            flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if (stall_ev_s && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt <= stall_cnt;
            end
            if (flush_ev_s && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                flush_cnt <= flush_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a reference model predicts the control
// vector each cycle, pushes it to a queue, and the sampled DUT output is
// popped and compared. HAZARD_PERF_EN also checks the counters.
module tb_hazard_ctrl;

    localparam int HALT_DRAIN = 2;

    logic       CLK = 1'b0;
    logic       RST, ihit, dhit, ex_dREN, mem_dREN, mem_dWEN, br_taken, halt_mem;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       pc_en, fd_freeze, fd_flush, dex_freeze, dex_flush;
    logic       xm_freeze, xm_flush, mw_freeze, halted;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
    logic [3:0]  stall_cnt4, flush_cnt4;
    logic        s_pc_en, s_fdz, s_fdf, s_dxz, s_dxf, s_xmz, s_xmf, s_mwz, s_hlt;
    longint      m_stall, m_flush;
`endif

    int n_vec  = 0;
    int n_miss = 0;
    int m_state;
    int m_cnt;
    logic [8:0] exp_q[$];

    always #5 CLK = ~CLK;

    hazard_ctrl #(.CNT_W(32), .HALT_DRAIN(HALT_DRAIN)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .id_rs(id_rs), .id_rt(id_rt),
        .ex_dREN(ex_dREN), .ex_rd(ex_rd), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
        .br_taken(br_taken), .halt_mem(halt_mem), .pc_en(pc_en),
        .fd_freeze(fd_freeze), .fd_flush(fd_flush), .dex_freeze(dex_freeze),
        .dex_flush(dex_flush), .xm_freeze(xm_freeze), .xm_flush(xm_flush),
        .mw_freeze(mw_freeze), .halted(halted)
`ifdef HAZARD_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

`ifdef HAZARD_PERF_EN
    hazard_ctrl #(.CNT_W(4), .HALT_DRAIN(HALT_DRAIN)) dut4 (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .id_rs(id_rs), .id_rt(id_rt),
        .ex_dREN(ex_dREN), .ex_rd(ex_rd), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
        .br_taken(br_taken), .halt_mem(halt_mem), .pc_en(s_pc_en),
        .fd_freeze(s_fdz), .fd_flush(s_fdf), .dex_freeze(s_dxz),
        .dex_flush(s_dxf), .xm_freeze(s_xmz), .xm_flush(s_xmf),
        .mw_freeze(s_mwz), .halted(s_hlt), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );
`endif

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected vector {pc_en, fd_frz, fd_fl, dex_frz, dex_fl, xm_frz, xm_fl, mw_frz, halted}
    function automatic logic [8:0] model_out();
        logic mw, lu;
        mw = (mem_dREN | mem_dWEN) & ~dhit;
        lu = ex_dREN && ex_rd != 5'd0 && (ex_rd == id_rs || ex_rd == id_rt);
        if (RST)               return 9'b0_0_1_0_1_0_1_0_0;
        if (m_state == 2)      return 9'b0_0_1_0_1_0_1_0_0;
        if (m_state == 3)      return 9'b0_1_0_1_0_1_0_1_1;
        if (mw)                return 9'b0_1_0_1_0_1_0_1_0;
        if (halt_mem)          return 9'b0_0_1_0_1_0_1_0_0;
        if (br_taken)          return 9'b1_0_1_0_1_0_1_0_0;
        if (lu)                return 9'b0_1_0_0_1_0_0_0_0;
        if (!ihit)             return 9'b0_0_1_0_0_0_0_0_0;
        return 9'b1_0_0_0_0_0_0_0_0;
    endfunction

    task automatic model_step(input logic [8:0] e);
        logic mw;
        mw = (mem_dREN | mem_dWEN) & ~dhit;
        if (RST) begin
            m_state = 0;
            m_cnt   = 0;
`ifdef HAZARD_PERF_EN
            m_stall = 0;
            m_flush = 0;
`endif
        end else if (m_state < 2) begin
`ifdef HAZARD_PERF_EN
            if (!e[8]) m_stall++;
            if (!mw && !halt_mem && br_taken) m_flush++;
`endif
            if (mw) m_state = 1;
            else if (halt_mem) begin
                m_state = 2;
                m_cnt   = HALT_DRAIN - 1;
            end else m_state = 0;
        end else if (m_state == 2) begin
            if (m_cnt == 0) m_state = 3;
            else m_cnt--;
        end
    endtask

    task automatic step(input string tag);
        logic [8:0] e, g;
        exp_q.push_back(model_out());
        #2;
        g = {pc_en, fd_freeze, fd_flush, dex_freeze, dex_flush, xm_freeze, xm_flush, mw_freeze, halted};
        e = exp_q.pop_front();
        check_eq(tag, 64'(g), 64'(e));
`ifdef HAZARD_PERF_EN
        if (!RST && m_state != -1) begin
            check_eq({tag, "_stall"}, 64'(stall_cnt), 64'(m_stall));
            check_eq({tag, "_flush"}, 64'(flush_cnt), 64'(m_flush));
            check_eq({tag, "_stall4"}, 64'(stall_cnt4), 64'((m_stall > 15) ? 15 : m_stall));
        end
`endif
        @(posedge CLK);
        model_step(e);
        #1;
    endtask

    task automatic drive(input logic rst, input logic ih, input logic dh, input logic er,
                         input logic [4:0] exr, input logic [4:0] rs, input logic [4:0] rt,
                         input logic dr, input logic dw, input logic br, input logic hm);
        RST = rst; ihit = ih; dhit = dh; ex_dREN = er; ex_rd = exr; id_rs = rs; id_rt = rt;
        mem_dREN = dr; mem_dWEN = dw; br_taken = br; halt_mem = hm;
    endtask

    task automatic idle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        m_state = 0;
        m_cnt   = 0;
`ifdef HAZARD_PERF_EN
        m_stall = 0;
        m_flush = 0;
`endif
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge CLK); #1;
        step("reset0");
        step("reset1");
        idle();                                     step("idle");
        // four stalls then two taken branches
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("no_ihit");
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        step("br0"); step("br1");
        idle();                                     step("idle2");
`ifdef HAZARD_PERF_EN
        check_eq("perf_stall4", 64'(stall_cnt), 64'd4);
        check_eq("perf_flush2", 64'(flush_cnt), 64'd2);
`endif
        drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0); step("loaduse");
        idle();                                     step("after_lu");
        drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); step("lu_r0");
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("dmiss");
        dhit = 1'b1;                                step("dmiss_hit");
        idle();                                     step("after_hit");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0); step("br_noihit");
        drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 5'd7, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0); step("st_miss_lu");
        dhit = 1'b1;                                step("st_hit_lu");
        // reset while waiting on data memory
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        step("dwait0"); step("dwait1");
        RST = 1'b1;                                 step("rst_dwait");
        idle();                                     step("post_rst_dwait");
        // halt held off by a miss, taken on the hit cycle
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        step("halt_wait0"); step("halt_wait1");
        dhit = 1'b1;                                step("halt_take");
        idle();
        step("drain0"); step("drain1");
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 5'd0, 5'd1,
                  5'd2, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            step("halted");
        end
        check_eq("halted_sticky", 64'(halted), 64'd1);
        RST = 1'b1;                                 step("rst_halt");
        idle();                                     step("halt_clr");
        // reset in the middle of the drain
        halt_mem = 1'b1; br_taken = 1'b1;           step("halt_vs_br");
        idle();                                     step("drain_a");
        RST = 1'b1;                                 step("rst_drain");
        idle();                                     step("post_rst_drain");
        // constrained-random phase
        for (int i = 0; i < 400; i++) begin
            drive(1'b0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 5)),
                  5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 29) == 0));
            if ((m_state == 3 && $urandom_range(0, 3) == 0) || $urandom_range(0, 59) == 0) RST = 1'b1;
            step("rand");
        end
`ifdef HAZARD_PERF_EN
        RST = 1'b1;                                 step("rst_sat");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step("sat");
        check_eq("sat_cnt4", 64'(stall_cnt4), 64'd15);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
